program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer that fills main memory with a VLIW program before the core runs. It accepts a byte stream over a valid/ready link, parses a small header, packs little-endian bytes into 32-bit words, and drives main memory's data write port one word per write. The core is held in reset until the load has completed successfully, so instruction fetch only ever reads a fully written image of 128-bit bundles.

## Interface
Parameters:
- `MAX_WORDS`, 16384: largest accepted payload length, in 32-bit words.
- `CNT_W`, 16: width of the word counter and length register; must hold `MAX_WORDS`.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load session.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts the byte this cycle.
- `mem_wr_addr` out 32: byte address of the word being written.
- `mem_wr_data` out 32: word being written.
- `mem_wr_en` out 1: single-cycle write strobe. Memory commits the write on this edge.
- `busy` out 1: a session is in progress.
- `done` out 1: the load completed successfully. Sticky until the next `start`.
- `error` out 1: the load was aborted. Sticky until the next `start`.
- `err_code` out 2: 0 = none, 1 = bad length, 2 = misaligned base, 3 = checksum.
- `core_rst_n` out 1: active-low reset to the core. Low unless in DONE.

## Operation
- States: IDLE, LEN, ADDR, DATA, CSUM, DONE, ERR.
- **Entering a session:** `start` in IDLE, DONE or ERR clears `done`, `error` and `err_code`, then goes to LEN. `start` in any other state is ignored.
- **Byte acceptance:** a byte is accepted on any cycle with `rx_valid && rx_ready`. `rx_ready` is 1 only in LEN, ADDR, DATA and CSUM.
- **LEN:** 4 bytes, LSB first, giving the word count N.
  - If N == 0, N > `MAX_WORDS`, or N is not a multiple of 4 (whole bundles only): ERR with code 1.
  - Otherwise go to ADDR.
- **ADDR:** 4 bytes, LSB first, giving base address B.
  - If B[3:0] != 0: ERR with code 2.
  - Otherwise go to DATA.
- **DATA:** each group of 4 accepted bytes is packed LSB first into word k (k = 0..N-1).
  - The cycle after the 4th byte: `mem_wr_en`=1, `mem_wr_addr` = B + 4k, `mem_wr_data` = word k.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - After word N-1 is written, the next state is CSUM (macro defined) or DONE.
- **DONE:** `core_rst_n`=1, `done`=1, `busy`=0.
- **ERR:** `core_rst_n`=0, `error`=1, `busy`=0. Words already written stay in memory.
- **`busy`** is 1 in LEN, ADDR, DATA and CSUM.
- **Stream gaps:** `rx_valid` gaps of any length are allowed. There is no timeout.

## Timing
- **Reset values** (async, on `rst`=0): state IDLE; `rx_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `core_rst_n`=0.
  - The core therefore stays in reset after power-up until a load completes.
- All outputs are registered.
- **Write latency:** exactly 1 cycle from acceptance of a word's 4th byte to `mem_wr_en`. The strobe is high for exactly 1 cycle.
  - `rx_ready` stays high during the strobe cycle, so back-to-back bytes are accepted with no bubble.
- **Header errors:** the state moves to ERR on the edge that accepts the offending 4th header byte. `rx_ready` is 0 the next cycle.
- **Completion without the macro:** DONE is entered on the same edge the final `mem_wr_en` is driven, and `core_rst_n` rises 1 cycle after that final write strobe.
- **Reset mid-session:** everything is aborted immediately to the reset values. There is no resume.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum of all payload bytes (mod 256) is kept.
  - After the final write the loader enters CSUM and accepts 1 checksum byte C.
  - If sum + C == 0 mod 256: DONE on the edge that accepts C.
  - Otherwise: ERR with code 3.
- `LOADER_CHECKSUM_EN` undefined:
  - No CSUM state and no sum register.
  - DATA goes directly to DONE, and no trailing byte is consumed.
  - `err_code` 3 is never produced.

## Structure
- Shared package `vliw_pkg` holds:
  - the `loader_state_e` enum;
  - the `loader_err_e` enum (NONE, LEN, ALIGN, CSUM);
  - `BUNDLE_WORDS` = 4 and `BUNDLE_BYTES` = 16.
- One sub-module, `byte_packer`: a 2-bit byte counter and a 32-bit shift register.
  - Inputs: byte strobe and `clear`.
  - Outputs: `word` and `word_valid` (high for 1 cycle).
  - It is reused for LEN, ADDR and DATA.

## Test plan
- **Basic load:** `start`, LEN=4, B=0x0000_0100, then bytes 0x00..0x0F streamed with `rx_valid` held high.
  - Expect 4 writes: 0x100←0x03020100, 0x104←0x07060504, 0x108←0x0B0A0908, 0x10C←0x0F0E0D0C.
  - Then `done`=1 and `core_rst_n`=1 (macro off).
- **Bad length:** LEN=6.
  - Expect ERR, `err_code`=1, `rx_ready`=0, and no `mem_wr_en` ever.
  - Repeat with LEN=0 and LEN=`MAX_WORDS`+4; both give the same result.
- **Misaligned base:** LEN=4, B=0x0000_0104.
  - Expect ERR, `err_code`=2.
- **Checksum (macro on):** payload bytes 0x00..0x0F, whose sum is 0x78.
  - C=0x88: expect DONE.
  - C=0x89: expect ERR with `err_code`=3, and all 4 words still written.
- **Backpressure:** `rx_valid` toggles randomly over a LEN=8 load.
  - Expect identical memory contents to the continuous case.
  - Expect exactly one `mem_wr_en` per 4 accepted payload bytes.
- **Reset mid-DATA:** drop `rst` after 2 words have been written.
  - Expect all outputs at their reset values asynchronously.
  - A following `start` runs a full fresh load correctly.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: loader FSM states, loader error codes and bundle geometry.
package vliw_pkg;

  localparam int unsigned BUNDLE_WORDS = 4;
  localparam int unsigned BUNDLE_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StAddr,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrLen   = 2'd1,
    ErrAlign = 2'd2,
    ErrCsum  = 2'd3
  } loader_err_e;

endpackage

// File: rtl/byte_packer.sv
// Packs little-endian bytes into 32-bit words; word/word_valid present the completed word
// combinationally on the cycle its 4th byte is strobed in.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (clear) begin
      cnt_q <= 2'd0;
    end else if (strobe) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {byte_in, sr_q[23:8]};
    end
  end

  // Only the three earlier bytes are stored; the 4th is the live input byte.
  assign word       = {byte_in, sr_q};
  assign word_valid = strobe && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length/base header from a byte stream and writes 32-bit words to memory.
// Define LOADER_CHECKSUM_EN to require a trailing byte that zeroes the mod-256 payload sum.
module program_loader
  import vliw_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        core_rst_n
);

  loader_state_e    state_q, state_d;
  loader_err_e      err_q, err_d;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [31:0]      addr_q;
  logic             accept, start_ok, pk_strobe, pk_valid, last_word;
  logic [31:0]      pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, csum_total;
  assign csum_total = sum_q + rx_data;
`endif

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state_q inside {StIdle, StDone, StErr});
  assign pk_strobe = accept && (state_q != StCsum);
  assign last_word = (cnt_q == len_q - CNT_W'(1));
  assign err_code  = err_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .strobe     (pk_strobe),
    .clear      (start_ok),
    .byte_in    (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          err_d   = ErrNone;
        end
      end
      StLen: begin
        if (pk_valid) begin
          if ((pk_word == 32'd0) || (pk_word > MAX_WORDS) ||
              ((pk_word & (BUNDLE_WORDS - 1)) != 0)) begin
            state_d = StErr;
            err_d   = ErrLen;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (pk_valid) begin
          if ((pk_word & (BUNDLE_BYTES - 1)) != 0) begin
            state_d = StErr;
            err_d   = ErrAlign;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (pk_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          if (csum_total == 8'd0) begin
            state_d = StDone;
          end else begin
            state_d = StErr;
            err_d   = ErrCsum;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      err_q       <= ErrNone;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= 32'd0;
      rx_ready    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= 32'd0;
      mem_wr_data <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      core_rst_n  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      rx_ready   <= state_d inside {StLen, StAddr, StData, StCsum};
      busy       <= state_d inside {StLen, StAddr, StData, StCsum};
      done       <= (state_d == StDone);
      error      <= (state_d == StErr);
      // Release the core only once DONE has been held for a full cycle.
      core_rst_n <= (state_q == StDone) && (state_d == StDone);
      mem_wr_en  <= 1'b0;
      if (state_q == StLen && pk_valid) begin
        len_q <= pk_word[CNT_W-1:0];
      end
      if (state_q == StAddr && pk_valid) begin
        addr_q <= pk_word;
        cnt_q  <= '0;
      end
      if (state_q == StData && pk_valid) begin
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= addr_q;
        mem_wr_data <= pk_word;
        addr_q      <= addr_q + 32'd4;
        cnt_q       <= cnt_q + CNT_W'(1);
      end
`ifdef LOADER_CHECKSUM_EN
      if (start_ok) begin
        sum_q <= 8'd0;
      end else if (state_q == StData && accept) begin
        sum_q <= sum_q + rx_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; define LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_program_loader;

  localparam int unsigned MaxWords = 16384;
  typedef logic [7:0] bytes_t[$];

  logic        clk, rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_wr_en, busy, done, error, core_rst_n;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [1:0]  err_code;

  int n_vec    = 0;
  int n_err    = 0;
  int wr_count = 0;

  program_loader #(
    .MAX_WORDS (MaxWords),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .core_rst_n  (core_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mem_wr_en === 1'b1) wr_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] csum_of(input bytes_t p);
    logic [7:0] s = 8'd0;
    foreach (p[i]) s = s + p[i];
    return 8'(8'd0 - s);
  endfunction

  task automatic pulse_start();
    rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int unsigned gapmax);
    int unsigned guard = 0;
    rx_valid = 1'b0;
    repeat ((gapmax == 0) ? 0 : $urandom_range(gapmax, 0)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (rx_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  // Runs a whole session; the expected outcome comes from the header/payload rules alone.
  task automatic send_session(input string name, input logic [31:0] len, input logic [31:0] base,
                              input bytes_t pay, input logic [7:0] csum, input int unsigned gapmax);
    logic [1:0]  exp_code;
    logic [31:0] exp_addr, exp_word;
    logic [7:0]  sum;
    int          wr0, exp_writes;
    exp_code = 2'd0;
    if (len == 0 || len > MaxWords || (len % 4) != 0) exp_code = 2'd1;
    else if ((base % 16) != 0) exp_code = 2'd2;
    exp_writes = (exp_code == 2'd0) ? int'(len) : 0;
    wr0 = wr_count;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gapmax);
    if (exp_code != 2'd1) begin
      for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8], gapmax);
    end
    if (exp_code == 2'd0) begin
      sum = 8'd0;
      for (int k = 0; k < int'(len); k++) begin
        for (int j = 0; j < 4; j++) begin
          send_byte(pay[4*k+j], gapmax);
          sum = sum + pay[4*k+j];
        end
        exp_word = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
        exp_addr = base + 32'(4 * k);
        n_vec++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== exp_addr || mem_wr_data !== exp_word) begin
          n_err++;
          $display("FAIL %s_word%0d: en=%b addr=%h data=%h required en=1 addr=%h data=%h",
                   name, k, mem_wr_en, mem_wr_addr, mem_wr_data, exp_addr, exp_word);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (8'(sum + csum) != 8'd0) exp_code = 2'd3;
      send_byte(csum, gapmax);
`endif
    end
    rx_valid = 1'b0;
    n_vec++;
    if (done !== (exp_code == 2'd0) || error !== (exp_code != 2'd0) || err_code !== exp_code ||
        busy !== 1'b0 || rx_ready !== 1'b0 || core_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL %s_status: done=%b error=%b code=%0d busy=%b rdy=%b crst=%b required %b %b %0d 0 0 0",
               name, done, error, err_code, busy, rx_ready, core_rst_n,
               exp_code == 2'd0, exp_code != 2'd0, exp_code);
    end
    @(negedge clk);
    n_vec++;
    if (core_rst_n !== (exp_code == 2'd0) || mem_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_core_rst: core_rst_n=%b wr_en=%b required %b 0",
               name, core_rst_n, mem_wr_en, exp_code == 2'd0);
    end
    n_vec++;
    if (wr_count - wr0 !== exp_writes) begin
      n_err++;
      $display("FAIL %s_write_count: writes=%0d required %0d", name, wr_count - wr0, exp_writes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #3;
    n_vec++;
    if ({rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error, err_code,
         core_rst_n} !== '0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b en=%b addr=%h data=%h busy=%b done=%b err=%b code=%0d crst=%b required all 0",
               rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error, err_code, core_rst_n);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rx_ready !== 1'b0 || busy !== 1'b0 || core_rst_n !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: rdy=%b busy=%b crst=%b done=%b required 0 0 0 0",
               rx_ready, busy, core_rst_n, done);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_basic();
    bytes_t p;
    for (int i = 0; i < 16; i++) p.push_back(8'(i));
    send_session("basic", 32'd4, 32'h0000_0100, p, csum_of(p), 0);
  endtask

  task automatic test_bad_len();
    bytes_t p;
    send_session("len6", 32'd6, 32'h0, p, 8'h00, 0);
    send_session("len0", 32'd0, 32'h0, p, 8'h00, 0);
    send_session("lenmax4", MaxWords + 4, 32'h0, p, 8'h00, 1);
  endtask

  task automatic test_misaligned();
    bytes_t p;
    send_session("misalign", 32'd4, 32'h0000_0104, p, 8'h00, 0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bytes_t p;
    for (int i = 0; i < 16; i++) p.push_back(8'(i));
    send_session("csum_good", 32'd4, 32'h0000_0200, p, 8'h88, 0);
    send_session("csum_bad", 32'd4, 32'h0000_0200, p, 8'h89, 0);
  endtask
`endif

  task automatic test_backpressure();
    bytes_t p;
    logic [31:0] base;
    for (int r = 0; r < 3; r++) begin
      p.delete();
      for (int i = 0; i < 32; i++) p.push_back(8'($urandom));
      base = (r == 2) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF0);
      send_session($sformatf("bp%0d", r), 32'd8, base, p, csum_of(p), (r == 2) ? 0 : 3);
    end
  endtask

  task automatic test_reset_mid_data();
    bytes_t p;
    logic [31:0] hdr_len  = 32'd8;
    logic [31:0] hdr_base = 32'h0000_2000;
    for (int i = 0; i < 32; i++) p.push_back(8'($urandom));
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(hdr_len[8*i +: 8], 0);
    for (int i = 0; i < 4; i++) send_byte(hdr_base[8*i +: 8], 0);
    for (int i = 0; i < 8; i++) send_byte(p[i], 0);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error, err_code,
         core_rst_n} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_values: rdy=%b en=%b addr=%h data=%h busy=%b done=%b err=%b code=%0d crst=%b required all 0",
               rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error, err_code, core_rst_n);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_session("after_reset", 32'd8, 32'h0000_3000, p, csum_of(p), 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_misaligned();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_backpressure();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
